// File: rtl/fact_seq.sv
// fact_seq: control sequencer and result holder for the fact_dp factorial datapath.
// Optional cycle counter on the cyc output is built only when FACT_SEQ_CYC_CNT_EN is defined.
module fact_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             clr,
  input  logic [WIDTH-1:0] n_in,
  input  logic             gt_in,
  input  logic             gt_fact,
  input  logic [WIDTH-1:0] nf,
  output logic [WIDTH-1:0] n,
  output logic             load_cnt,
  output logic             en,
  output logic             sel_1,
  output logic             load_reg,
  output logic             sel_2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [15:0]      cyc
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CHK  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t state_r;

  // Sequencer: strobes are registered for the state being entered, so they are high exactly while in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      n        <= '0;
      load_cnt <= 1'b0;
      en       <= 1'b0;
      sel_1    <= 1'b0;
      load_reg <= 1'b0;
      sel_2    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      load_cnt <= 1'b0;
      en       <= 1'b0;
      sel_1    <= 1'b0;
      load_reg <= 1'b0;
      sel_2    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go) begin
            n        <= n_in;
            done     <= 1'b0;
            err      <= 1'b0;
            load_cnt <= 1'b1;
            load_reg <= 1'b1;
            busy     <= 1'b1;
            state_r  <= LOAD;
          end else if (clr) begin
            done <= 1'b0;
            err  <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          state_r <= CHK;
        end
        CHK: begin
          if (gt_in) begin
            state_r <= ERR;
          end else if (gt_fact) begin
            // Multiply and decrement share one edge: the product uses the pre-decrement count.
            sel_1    <= 1'b1;
            load_reg <= 1'b1;
            en       <= 1'b1;
            state_r  <= MUL;
          end else begin
            sel_2   <= 1'b1;
            state_r <= DONE;
          end
        end
        MUL: begin
          state_r <= CHK;
        end
        DONE: begin
          result  <= nf;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        ERR: begin
          result  <= '0;
          err     <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef FACT_SEQ_CYC_CNT_EN
  logic [15:0] cyc_cnt_r;
  logic [15:0] cyc_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Busy-cycle counter; the completion edge itself is included in the captured value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_r <= 16'd0;
      cyc_r     <= 16'd0;
    end else begin
      if (state_r == IDLE && go) begin
        cyc_cnt_r <= 16'd0;
      end else if (busy) begin
        cyc_cnt_r <= sat_inc(cyc_cnt_r);
      end else begin
        cyc_cnt_r <= cyc_cnt_r;
      end
      if (state_r == DONE || state_r == ERR) begin
        cyc_r <= sat_inc(cyc_cnt_r);
      end else begin
        cyc_r <= cyc_r;
      end
    end
  end

  assign cyc = cyc_r;
`else
  assign cyc = 16'd0;
`endif

endmodule

// File: doc/fact_seq.md
# fact_seq

Sequencer and result-holding front end for the factorial datapath `fact_dp`. It accepts a start request with an operand `n` and drives every `fact_dp` control strobe (`load_cnt`, `en`, `sel_1`, `load_reg`, `sel_2`). It consumes the datapath's `gt_in` / `gt_fact` flags and its `nf` product, then holds the final result and sticky done/error status for the SoC bus-facing register block. `fact_dp` has no reset; `fact_seq` guarantees the datapath is never strobed out of reset.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match `fact_dp`.

Ports:
- `clk`, in, 1, the single clock; all state updates on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `go`, in, 1, start request; sampled only in IDLE.
- `clr`, in, 1, clears sticky `done` and `err` in IDLE.
- `n_in`, in, WIDTH, operand; captured when `go` is accepted.
- `gt_in`, in, 1, from `fact_dp` (n > 12).
- `gt_fact`, in, 1, from `fact_dp` (count > 1).
- `nf`, in, WIDTH, product from `fact_dp`.
- `n`, out, WIDTH, registered operand to `fact_dp`.
- `load_cnt`, `en`, `sel_1`, `load_reg`, `sel_2`, out, 1 each, `fact_dp` strobes.
- `busy`, out, 1, high in every state except IDLE.
- `done`, out, 1, sticky: a successful result is valid.
- `err`, out, 1, sticky: operand out of range.
- `result`, out, WIDTH, held n!; 0 after reset or error.
- `cyc`, out, 16, cycle count of the last operation. Reads 0 unless the macro below is defined.

## Operation
State machine states: IDLE, LOAD, CHK, MUL, DONE, ERR. All outputs are registered or decoded from state only.
- IDLE: all strobes 0.
  - `go`=1: capture `n_in` into `n`, clear `done`/`err`, go to LOAD.
  - `clr` without `go`: clear `done`/`err` and stay in IDLE.
  - `go` together with `clr`: `go` wins, and the flags are cleared anyway.
- LOAD: `load_cnt`=1, `load_reg`=1, `sel_1`=0. The counter loads `n` and the product register is set to 1. Go to CHK.
- CHK: no strobes.
  - `gt_in`: go to ERR.
  - else `gt_fact`: go to MUL.
  - else: go to DONE.
- MUL: `sel_1`=1, `load_reg`=1, `en`=1 on the same edge. The product uses the pre-decrement count. Go to CHK.
- DONE: `sel_2`=1. Set `result` to `nf`, set `done`=1. Go to IDLE.
- ERR: set `result`=0, set `err`=1. Go to IDLE.
- `go` is ignored while `busy`=1; requests are not queued.
- `n`=0 and `n`=1 both produce 1. Arithmetic wrap is impossible because the `gt_in` check bounds n to 12 or less.

## Timing
- Reset values: state IDLE, `n`=0, all strobes 0, `busy`=0, `done`=0, `err`=0, `result`=0, `cyc`=0.
- `rst` mid-operation aborts to IDLE on the next edge with the reset values above. Datapath contents are don't-care.
- Accept edge E0 is the edge that samples `go`=1 in IDLE. `busy` is high from E0.
- Valid operand, n ≥ 1: `done` and `result` are valid after edge E0+2n+1. `busy` falls on the same edge.
- n = 0: completion is at E0+3.
- Invalid operand: `err` is set at E0+3.
- Back-to-back: the earliest next accept is the edge after `busy` falls, giving one idle cycle between operations.
- `result` is stable from completion until the next DONE, ERR or `rst`. It is not cleared by `clr` or `go`.

## Configuration
- `FACT_SEQ_CYC_CNT_EN` defined:
  - A 16-bit counter clears at E0 and increments every cycle `busy`=1.
  - It is copied to `cyc` at completion, both DONE and ERR, and saturates at 16'hFFFF.
- Not defined: no counter logic is built and `cyc` is tied to 0.

## Test plan
- Reset, then `n_in`=5 with a 1-cycle `go`: `busy` for 11 cycles, then `result`=120, `done`=1, `err`=0. With the macro defined, `cyc`=11.
- `n_in`=0, then `n_in`=1: each gives `result`=1 and `done` at E0+3.
- `n_in`=12: `result`=479001600 (0x1C8CFC00) at E0+25.
- `n_in`=13: `err`=1 at E0+3, `result`=0, `done`=0, and `load_reg` never asserted with `sel_1`=1.
- `go` pulsed mid-operation on `n_in`=4: ignored, the first result of 24 is unaffected. Then `clr`: `done` falls and `result` stays 24.
- `rst` asserted in MUL during `n_in`=7: next cycle IDLE with all outputs at reset values. A new `go` with `n_in`=3 then yields 6.
